// File: rtl/simple_pkg.sv
// Shared encodings for the SIMPLE instruction sequencer.
// Covers the opcode fields, the FSM state set and the registered control word.
package simple_pkg;

    localparam logic [1:0] OP1_EXT = 2'b10;
    localparam logic [1:0] OP1_ALU = 2'b11;

    localparam logic [3:0] OP3_ADD = 4'd0;
    localparam logic [3:0] OP3_SUB = 4'd1;
    localparam logic [3:0] OP3_AND = 4'd2;
    localparam logic [3:0] OP3_OR  = 4'd3;
    localparam logic [3:0] OP3_XOR = 4'd4;
    localparam logic [3:0] OP3_CMP = 4'd5;
    localparam logic [3:0] OP3_MOV = 4'd6;
    localparam logic [3:0] OP3_SLL = 4'd8;
    localparam logic [3:0] OP3_SLR = 4'd9;
    localparam logic [3:0] OP3_SRL = 4'd10;
    localparam logic [3:0] OP3_SRA = 4'd11;
    localparam logic [3:0] OP3_IN  = 4'd12;
    localparam logic [3:0] OP3_OUT = 4'd13;
    localparam logic [3:0] OP3_HLT = 4'd15;

    localparam logic [2:0] OP2_LI  = 3'b000;
    localparam logic [2:0] OP2_B   = 3'b100;
    localparam logic [2:0] OP2_BCC = 3'b111;

    localparam logic [2:0] COND_BE  = 3'b000;
    localparam logic [2:0] COND_BLT = 3'b001;
    localparam logic [2:0] COND_BLE = 3'b010;
    localparam logic [2:0] COND_BNE = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_WB     = 3'd4,
        ST_HALT   = 3'd5
    } state_t;

    typedef struct packed {
        logic       alu_en;
        logic       sft_en;
        logic       immd_en;
        logic       in_en;
        logic       out_en;
        logic [3:0] op3;
        logic [7:0] immd;
        logic [2:0] ar_idx;
        logic [2:0] br_idx;
        logic [2:0] wr_idx;
        logic       rd_ar_en;
        logic       rd_br_en;
        logic       wr_en;
    } ctrl_t;

endpackage

// File: rtl/simple_if.sv
// Sequencer-side bundle: instruction memory port, run/halt and datapath controls.
// master = simple_ctrl, slave = memory/datapath side.
interface simple_if #(
    parameter int PC_W = 16
);
    logic            run;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [15:0]     imem_data;
    logic [3:0]      szcv;
    logic            alu_en;
    logic            sft_en;
    logic            immd_en;
    logic            in_en;
    logic            out_en;
    logic [3:0]      op3;
    logic [7:0]      immd;
    logic [2:0]      AR_idx;
    logic [2:0]      BR_idx;
    logic [2:0]      wr_idx;
    logic            rdAR_en;
    logic            rdBR_en;
    logic            wr_en;
    logic            wrclk;
    logic            halted;

    modport master (
        input  run, imem_data, szcv,
        output imem_addr, imem_rd, alu_en, sft_en, immd_en, in_en, out_en,
               op3, immd, AR_idx, BR_idx, wr_idx, rdAR_en, rdBR_en, wr_en,
               wrclk, halted
    );

    modport slave (
        output run, imem_data, szcv,
        input  imem_addr, imem_rd, alu_en, sft_en, immd_en, in_en, out_en,
               op3, immd, AR_idx, BR_idx, wr_idx, rdAR_en, rdBR_en, wr_en,
               wrclk, halted
    );
endinterface

// File: rtl/simple_decode.sv
// Combinational decode of one SIMPLE instruction word into the datapath control word,
// plus branch-taken (evaluated on the latched flags) and halt indications.
module simple_decode
    import simple_pkg::*;
(
    input  logic [15:0] ir,
    input  logic [3:0]  flags,
    output ctrl_t       cw,
    output logic        taken,
    output logic        halt
);

    logic [2:0] rs;
    logic [2:0] rd;
    logic [2:0] op2;
    logic [3:0] op3;
    logic       s_f;
    logic       z_f;
    logic       c_unused;
    logic       v_f;

    assign rs  = ir[13:11];
    assign rd  = ir[10:8];
    assign op2 = ir[13:11];
    assign op3 = ir[7:4];
    assign {s_f, z_f, c_unused, v_f} = flags;

    always_comb begin
        cw      = '0;
        taken   = 1'b0;
        halt    = 1'b0;
        cw.op3  = op3;
        cw.immd = ir[7:0];
        if (ir[15:14] == OP1_ALU) begin
            case (op3)
                OP3_ADD, OP3_SUB, OP3_AND, OP3_OR, OP3_XOR, OP3_CMP, OP3_MOV: begin
                    cw.alu_en   = 1'b1;
                    cw.ar_idx   = rd;
                    cw.br_idx   = rs;
                    cw.rd_ar_en = 1'b1;
                    cw.rd_br_en = 1'b1;
                    cw.wr_idx   = rd;
                    cw.wr_en    = (op3 != OP3_CMP);
                end
                OP3_SLL, OP3_SLR, OP3_SRL, OP3_SRA: begin
                    cw.sft_en   = 1'b1;
                    cw.br_idx   = rd;
                    cw.rd_br_en = 1'b1;
                    cw.wr_idx   = rd;
                    cw.wr_en    = 1'b1;
                end
                OP3_IN: begin
                    cw.in_en  = 1'b1;
                    cw.wr_idx = rd;
                    cw.wr_en  = 1'b1;
                end
                OP3_OUT: begin
                    cw.out_en   = 1'b1;
                    cw.br_idx   = rs;
                    cw.rd_br_en = 1'b1;
                end
                OP3_HLT: halt = 1'b1;
                default: ;
            endcase
        end else if (ir[15:14] == OP1_EXT) begin
            case (op2)
                OP2_LI: begin
                    cw.immd_en = 1'b1;
                    cw.wr_idx  = rd;
                    cw.wr_en   = 1'b1;
                end
                OP2_B: taken = 1'b1;
                OP2_BCC: begin
                    case (ir[10:8])
                        COND_BE:  taken = z_f;
                        COND_BLT: taken = s_f ^ v_f;
                        COND_BLE: taken = z_f | (s_f ^ v_f);
                        COND_BNE: taken = ~z_f;
                        default:  taken = 1'b0;
                    endcase
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/simple_ctrl.sv
// SIMPLE instruction sequencer: fetch/decode/execute/write-back FSM holding PC, IR and flags.
// state  | meaning
// IDLE   | waiting for run
// FETCH  | imem_rd high, imem_addr = PC
// DECODE | imem_data captured into IR, control word registered
// EXEC   | control word driven, flags/PC updated at exit
// WB     | control word held, wrclk high for this cycle only
// HALT   | halted high, everything else low until reset
module simple_ctrl
    import simple_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
)
(
    input  logic     clk,
    input  logic     reset,
    simple_if.master bus
);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [15:0]     ir;
    logic [3:0]      flags;
    ctrl_t           cw_q;
    logic            imem_rd_q;
    logic            wrclk_q;
    logic            halted_q;

    logic [15:0]     dec_ir;
    ctrl_t           dec_cw;
    logic            dec_taken;
    logic            dec_halt;
    logic [PC_W-1:0] pc_inc;
    logic [PC_W-1:0] pc_br;

    // In DECODE the word is still on the memory bus, so the control word can be
    // registered at EXEC entry and stay stable for the whole EXEC cycle.
    assign dec_ir = (state == ST_DECODE) ? bus.imem_data : ir;

    simple_decode u_decode (
        .ir    (dec_ir),
        .flags (flags),
        .cw    (dec_cw),
        .taken (dec_taken),
        .halt  (dec_halt)
    );

    assign pc_inc = pc + PC_W'(1);
    assign pc_br  = pc_inc + PC_W'($signed(ir[7:0]));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            ir        <= '0;
            flags     <= '0;
            cw_q      <= '0;
            imem_rd_q <= 1'b0;
            wrclk_q   <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.run) begin
                        state     <= ST_FETCH;
                        imem_rd_q <= 1'b1;
                    end
                end
                ST_FETCH: begin
                    imem_rd_q <= 1'b0;
                    state     <= ST_DECODE;
                end
                ST_DECODE: begin
                    ir    <= bus.imem_data;
                    cw_q  <= dec_cw;
                    state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (cw_q.alu_en || cw_q.sft_en)
                        flags <= bus.szcv;
                    pc <= dec_taken ? pc_br : pc_inc;
                    if (dec_halt) begin
                        cw_q     <= '0;
                        halted_q <= 1'b1;
                        state    <= ST_HALT;
                    end else if (cw_q.wr_en) begin
                        wrclk_q <= 1'b1;
                        state   <= ST_WB;
                    end else begin
                        cw_q      <= '0;
                        imem_rd_q <= 1'b1;
                        state     <= ST_FETCH;
                    end
                end
                ST_WB: begin
                    cw_q      <= '0;
                    wrclk_q   <= 1'b0;
                    imem_rd_q <= 1'b1;
                    state     <= ST_FETCH;
                end
                ST_HALT: ;
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.imem_addr = halted_q ? '0 : pc;
    assign bus.imem_rd   = imem_rd_q;
    assign bus.alu_en    = cw_q.alu_en;
    assign bus.sft_en    = cw_q.sft_en;
    assign bus.immd_en   = cw_q.immd_en;
    assign bus.in_en     = cw_q.in_en;
    assign bus.out_en    = cw_q.out_en;
    assign bus.op3       = cw_q.op3;
    assign bus.immd      = cw_q.immd;
    assign bus.AR_idx    = cw_q.ar_idx;
    assign bus.BR_idx    = cw_q.br_idx;
    assign bus.wr_idx    = cw_q.wr_idx;
    assign bus.rdAR_en   = cw_q.rd_ar_en;
    assign bus.rdBR_en   = cw_q.rd_br_en;
    assign bus.wr_en     = cw_q.wr_en;
    assign bus.wrclk     = wrclk_q;
    assign bus.halted    = halted_q;

endmodule

// File: tb/tb_simple_ctrl.sv
// Bench for simple_ctrl: directed and random instructions checked against an
// instruction-level model of PC, flags and expected control outputs.
module tb_simple_ctrl;

    logic clk = 1'b0;
    logic reset;

    simple_if #(.PC_W(16)) bus ();

    simple_ctrl #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    logic [15:0] m_pc;
    logic [3:0]  m_flags;

    localparam int K_NOP = 0, K_ALU = 1, K_CMP = 2, K_SFT = 3, K_IN = 4,
                   K_OUT = 5, K_HLT = 6, K_LI = 7, K_B = 8, K_BCC = 9;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int kind_of(input logic [15:0] w);
        int op1 = int'(w[15:14]);
        int op2 = int'(w[13:11]);
        int op3 = int'(w[7:4]);
        if (op1 == 3) begin
            if (op3 == 5) return K_CMP;
            if (op3 <= 6) return K_ALU;
            if (op3 >= 8 && op3 <= 11) return K_SFT;
            if (op3 == 12) return K_IN;
            if (op3 == 13) return K_OUT;
            if (op3 == 15) return K_HLT;
            return K_NOP;
        end
        if (op1 == 2) begin
            if (op2 == 0) return K_LI;
            if (op2 == 4) return K_B;
            if (op2 == 7) return K_BCC;
        end
        return K_NOP;
    endfunction

    // {alu,sft,immd_en,in,out, op3, immd, AR, BR, wr_idx, rdAR, rdBR, wr_en}
    function automatic logic [28:0] exp_ctrl(input logic [15:0] w);
        int  k  = kind_of(w);
        int  rs = int'(w[13:11]);
        int  rd = int'(w[10:8]);
        bit  alu = 0, sft = 0, imm = 0, inn = 0, outp = 0, ra = 0, rb = 0, we = 0;
        int  ar = 0, br = 0, wi = 0;
        case (k)
            K_ALU, K_CMP: begin
                alu = 1; ar = rd; br = rs; ra = 1; rb = 1; wi = rd; we = (k == K_ALU);
            end
            K_SFT: begin sft = 1; br = rd; rb = 1; wi = rd; we = 1; end
            K_IN:  begin inn = 1; wi = rd; we = 1; end
            K_OUT: begin outp = 1; br = rs; rb = 1; end
            K_LI:  begin imm = 1; wi = rd; we = 1; end
            default: ;
        endcase
        return {alu, sft, imm, inn, outp, w[7:4], w[7:0], 3'(ar), 3'(br), 3'(wi), ra, rb, we};
    endfunction

    function automatic bit cond_ok(input logic [15:0] w, input logic [3:0] f);
        bit s = f[3];
        bit z = f[2];
        bit v = f[0];
        case (int'(w[10:8]))
            0:       return z;
            1:       return s ^ v;
            2:       return z | (s ^ v);
            3:       return !z;
            default: return 0;
        endcase
    endfunction

    function automatic logic [28:0] obs_ctrl();
        return {bus.alu_en, bus.sft_en, bus.immd_en, bus.in_en, bus.out_en, bus.op3, bus.immd,
                bus.AR_idx, bus.BR_idx, bus.wr_idx, bus.rdAR_en, bus.rdBR_en, bus.wr_en};
    endfunction

    function automatic logic [31:0] obs_all();
        return {bus.halted, bus.imem_rd, bus.wrclk, obs_ctrl()};
    endfunction

    // Runs one instruction from its FETCH cycle to the next FETCH (or HALT).
    task automatic step(input logic [15:0] w, input logic [3:0] sz);
        int          n = 0;
        int          k;
        logic [28:0] ec;
        logic [15:0] npc;
        while (bus.imem_rd !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("fetch_wait", 32'(n < 20), 1);
        if (n >= 20) return;
        chk("fetch_addr", 32'(bus.imem_addr), 32'(m_pc));
        chk("fetch_quiet", {bus.halted, bus.wrclk, obs_ctrl()}, 0);
        bus.imem_data = w;
        bus.szcv      = sz;
        bus.run       = 1'($urandom_range(0, 1));
        @(negedge clk);
        chk("decode_quiet", obs_all(), 0);
        @(negedge clk);
        k  = kind_of(w);
        ec = exp_ctrl(w);
        chk("exec_ctrl", 32'(obs_ctrl()), 32'(ec));
        chk("exec_strobes", {bus.halted, bus.imem_rd, bus.wrclk}, 0);
        if (k == K_B || (k == K_BCC && cond_ok(w, m_flags)))
            npc = m_pc + 16'd1 + {{8{w[7]}}, w[7:0]};
        else
            npc = m_pc + 16'd1;
        if (k == K_ALU || k == K_CMP || k == K_SFT)
            m_flags = sz;
        m_pc = npc;
        @(negedge clk);
        if (k == K_HLT) begin
            chk("halt_enter", obs_all(), 32'h8000_0000);
            return;
        end
        if (ec[0]) begin
            chk("wb_ctrl", 32'(obs_ctrl()), 32'(ec));
            chk("wb_wrclk", {bus.imem_rd, bus.wrclk}, 2'b01);
            @(negedge clk);
        end
        chk("next_fetch", {bus.imem_rd, bus.wrclk, bus.halted}, 3'b100);
    endtask

    initial begin
        logic [15:0] w;
        reset         = 1'b1;
        bus.run       = 1'b0;
        bus.imem_data = 16'h0000;
        bus.szcv      = 4'h0;
        m_pc          = 16'h0000;
        m_flags       = 4'h0;

        @(negedge clk);
        chk("reset_outputs", obs_all(), 0);
        chk("reset_addr", 32'(bus.imem_addr), 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("idle_no_fetch", obs_all(), 0);
        end
        bus.run = 1'b1;

        step(16'h8105, 4'b0000);   // LI R1,5
        step(16'hD100, 4'b0100);   // ADD R1,R2 -> Z=1
        step(16'hB8FE, 4'b0000);   // BE -2, taken
        step(16'hD100, 4'b0000);   // ADD, Z=0
        step(16'hB8FE, 4'b0000);   // BE -2, not taken
        step(16'hC382, 4'b1000);   // SLL R3,2 -> S=1
        step(16'hB902, 4'b0000);   // BLT +2, taken
        step(16'hBA01, 4'b0000);   // BLE +1, taken
        step(16'hBB01, 4'b0000);   // BNE +1, taken
        step(16'hBC05, 4'b0000);   // undefined cond, falls through
        step(16'hE0D0, 4'b0000);   // OUT R4
        step(16'hE5C0, 4'b0000);   // IN R5
        step(16'hE350, 4'b0001);   // CMP: flags only, no write
        step(16'hA003, 4'b0000);   // B +3
        step(16'hA080, 4'b0000);   // B -128, wraps below zero
        step(16'hA07F, 4'b0000);   // B +127, wraps back

        for (int i = 0; i < 60; i++) begin
            w = 16'($urandom);
            if (w[15:14] == 2'b11 && w[7:4] == 4'hF)
                w[7:4] = 4'h0;
            step(w, 4'($urandom));
        end

        // Asynchronous reset while a write-back is in progress.
        bus.run       = 1'b1;
        bus.imem_data = 16'h8305;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_wrclk", {bus.wrclk, bus.wr_en}, 2'b11);
        #2 reset = 1'b1;
        #1;
        chk("reset_wb_drop", {bus.wrclk, bus.wr_en}, 0);
        chk("reset_wb_all", obs_all(), 0);
        chk("reset_wb_addr", 32'(bus.imem_addr), 0);
        @(negedge clk);
        reset   = 1'b0;
        m_pc    = 16'h0000;
        m_flags = 4'h0;

        step(16'hD100, 4'b0000);
        step(16'hC0F0, 4'b0000);   // HLT
        for (int i = 0; i < 6; i++) begin
            bus.run = ~bus.run;
            @(negedge clk);
            chk("halt_hold", obs_all(), 32'h8000_0000);
            chk("halt_addr", 32'(bus.imem_addr), 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/simple_ctrl.md
Name: simple_ctrl

Overview:
- Instruction sequencer and decoder that sits directly upstream of the 16-bit SIMPLE datapath.
- Fetches instructions from a synchronous instruction memory and decodes SIMPLE arithmetic, shift, I/O, load-immediate and branch formats.
- Drives every datapath control input, including the register-file write strobe wrclk.
- Keeps PC, IR and a latched SZCV flag register; a multi-cycle FSM executes one instruction at a time.

Parameters:
PC_W, 16, width of program counter and imem_addr
RESET_PC, 0, PC value loaded on reset

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
run  in  1  leaves IDLE when high
imem_addr  out  PC_W  instruction address (= PC)
imem_rd  out  1  read strobe; imem_data valid on the following cycle
imem_data  in  16  instruction word
szcv  in  4  datapath flags {S,Z,C,V}, valid combinationally while alu_en/sft_en asserted
alu_en, sft_en, immd_en, in_en, out_en  out  1 each  bus_T source selects / output latch enable
op3  out  4  ALU/shift operation (IR[7:4])
immd  out  8  immediate (IR[7:0]; shift amount uses low 4 bits)
AR_idx, BR_idx, wr_idx  out  3 each  register indices
rdAR_en, rdBR_en, wr_en  out  1 each  register-file enables
wrclk  out  1  register-file write clock, registered
halted  out  1  high in HALT state

Behaviour:
- Reset (async):
  - State IDLE, PC=RESET_PC, IR=0, flags=0.
  - All outputs 0.
- Instruction fields:
  - op1=IR[15:14], Rs=IR[13:11], Rd=IR[10:8], op3=IR[7:4], d=IR[3:0].
- FSM states: IDLE, FETCH, DECODE, EXEC, WB, HALT.
- IDLE: go to FETCH when run=1.
- FETCH: imem_rd=1, imem_addr=PC, then DECODE.
- DECODE: IR<=imem_data, then EXEC.
- EXEC (control outputs registered from IR, stable whole cycle):
  - Arithmetic, op1=11, op3 0-6 (ADD,SUB,AND,OR,XOR,CMP,MOV): alu_en=1, AR_idx=Rd, BR_idx=Rs, rdAR_en=rdBR_en=1, wr_idx=Rd, wr_en=1 (0 for CMP). Flags latched from szcv at end of EXEC.
  - Shift, op3 8-11: sft_en=1, BR_idx=Rd, rdBR_en=1, wr_idx=Rd, wr_en=1. Flags latched.
  - IN, op3=12: in_en=1, wr_idx=Rd, wr_en=1.
  - OUT, op3=13: out_en=1 (one cycle only), BR_idx=Rs, rdBR_en=1.
  - HLT, op3=15: go to HALT.
  - LI, op1=10 and IR[13:11]=000: immd_en=1, wr_idx=Rd, wr_en=1.
  - B, op1=10 and IR[13:11]=100: PC<=PC+1+sext(IR[7:0]).
  - Conditional branch, op1=10 and IR[13:11]=111, cond=IR[10:8], evaluated on latched flags:
    - 000 BE: Z.
    - 001 BLT: S^V.
    - 010 BLE: Z|(S^V).
    - 011 BNE: !Z.
    - Taken: PC<=PC+1+sext(IR[7:0]). Not taken or other cond: PC+1.
  - All other encodings (op1=00/01, op3 7/14, other op2): NOP, PC+1.
- Next state after EXEC:
  - wr_en=1: go to WB.
  - Otherwise: go to FETCH.
  - Non-branch instructions: PC<=PC+1 at EXEC exit.
- WB:
  - Enables, indices and wr_en held from EXEC; wrclk=1 for exactly this cycle, rising at WB entry after bus_T was stable through EXEC.
  - PC+1 already applied; next state FETCH.
- Cycle counts: instructions with a write take 4 cycles (FETCH..WB); all others take 3.
- At most one bus_T source enable is high in any cycle; all enables are 0 in IDLE, FETCH, DECODE and HALT.
- PC wraps modulo 2^PC_W.
- HALT: halted=1, all other outputs 0, exit only via reset.
- run is ignored outside IDLE.
- Reset mid-operation: immediate return to IDLE with all outputs 0, including wrclk if in WB.

Decomposition:
- Package simple_pkg:
  - op1 codes, op3 codes (ADD..HLT), op2 codes (LI=000, B=100, BCC=111), cond codes.
  - FSM state enum.
- One sub-module simple_decode: combinational IR + flags to control word and branch-taken flag. The FSM and registers stay in simple_ctrl.

Test Plan:
- Reset, run=1, imem_data=0x8105 (LI R1,5) -> EXEC: immd_en=1, immd=0x05, wr_idx=1, wr_en=1; WB: wrclk=1 one cycle; imem_addr=1 at next FETCH.
- 0xD100 (ADD R1,R2) with szcv=0100 -> EXEC: alu_en=1, op3=0, AR_idx=1, BR_idx=2, wr_idx=1; flags latched Z=1; then 0xB8FE (BE -2) at PC=1 -> PC becomes 0.
- Same BE with Z=0 latched -> PC=2; no wrclk pulse; 3-cycle instruction.
- 0xC382 (SLL R3,2) -> sft_en=1, op3=8, immd[3:0]=2, BR_idx=3, wr_idx=3; 0xE0D0 (OUT R4) -> out_en=1 for one cycle, BR_idx=4, wr_en=0.
- 0xA003 (B +3) at PC=5 -> next imem_addr=9; 0xC0F0 (HLT) -> halted=1, imem_rd stays 0 with run toggling.
- Assert reset during WB -> wrclk and wr_en drop asynchronously, state IDLE, imem_addr=RESET_PC.
